// File: rtl/hwpe_stream_package.sv
// hwpe_stream_package: shared TCDM op encoding and stall LFSR taps
package hwpe_stream_package;
  typedef enum logic {
    TCDM_OP_WRITE = 1'b0,
    TCDM_OP_READ  = 1'b1
  } tcdm_op_e;
  // x^8+x^6+x^5+x^4+1 as a mask over lfsr[7:0], feedback shifted into bit 0
  localparam logic [7:0] TCDM_STALL_LFSR_TAPS = 8'hB8;
endpackage

// File: rtl/hwpe_stream_intf_tcdm.sv
// hwpe_stream_intf_tcdm: TCDM request/response bundle between a master and a memory responder
interface hwpe_stream_intf_tcdm;
  logic        req;
  logic        gnt;
  logic [31:0] add;
  logic        wen;
  logic [3:0]  be;
  logic [31:0] data;
  logic [31:0] r_data;
  logic        r_valid;
  modport master (output req, add, wen, be, data, input gnt, r_data, r_valid);
  modport slave  (input req, add, wen, be, data, output gnt, r_data, r_valid);
endinterface

// File: rtl/hwpe_stream_tcdm_stall_gen.sv
// hwpe_stream_tcdm_stall_gen: free-running 8-bit Fibonacci LFSR that flags grant stalls below a threshold
module hwpe_stream_tcdm_stall_gen
  import hwpe_stream_package::*;
#(
  parameter logic [7:0]  SEED   = 8'hA5,
  parameter int unsigned THRESH = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  output logic stall_o
);
  logic [7:0] lfsr;
  // advance every cycle regardless of traffic; clear restarts the sequence
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr <= SEED;
    else         lfsr <= clear_i ? SEED : {lfsr[6:0], ^(lfsr & TCDM_STALL_LFSR_TAPS)};
  end
  // widened compare so THRESH=256 means always stall
  assign stall_o = {24'b0, lfsr} < THRESH;
endmodule

// File: rtl/hwpe_stream_tcdm_responder.sv
// hwpe_stream_tcdm_responder: byte-enabled single-port TCDM memory with 1-cycle reads and transaction counters; define HWPE_TCDM_RESPONDER_STALL_EN for random grant stalls
module hwpe_stream_tcdm_responder
  import hwpe_stream_package::*;
#(
  parameter int unsigned MEM_WORDS    = 256,
  parameter logic [7:0]  STALL_SEED   = 8'hA5,
  parameter int unsigned STALL_THRESH = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  hwpe_stream_intf_tcdm.slave  tcdm,
  output logic [31:0]          nb_reads_o,
  output logic [31:0]          nb_writes_o
);
  localparam int unsigned AW = $clog2(MEM_WORDS);
  logic [31:0]   mem [MEM_WORDS];
  logic [AW-1:0] idx;
  logic          stall, rd_hs, wr_hs, r_valid;
  logic [31:0]   r_data, nb_reads, nb_writes;
  logic          unused_add;
`ifdef HWPE_TCDM_RESPONDER_STALL_EN
  hwpe_stream_tcdm_stall_gen #(
    .SEED   (STALL_SEED),
    .THRESH (STALL_THRESH)
  ) i_stall_gen (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .stall_o (stall)
  );
`else
  logic unused_cfg;
  assign stall      = 1'b0;
  assign unused_cfg = ^{STALL_SEED, STALL_THRESH};
`endif
  // word-aligned index; byte offset and out-of-range bits wrap away
  assign idx        = tcdm.add[2 +: AW];
  assign unused_add = ^{tcdm.add[31:AW+2], tcdm.add[1:0]};
  assign tcdm.gnt   = tcdm.req & ~stall;
  assign rd_hs      = tcdm.gnt & (tcdm.wen == TCDM_OP_READ);
  assign wr_hs      = tcdm.gnt & (tcdm.wen == TCDM_OP_WRITE);
  // byte-masked write port; clear never blocks a write
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= '0;
    end else if (wr_hs) begin
      for (int i = 0; i < 4; i++) if (tcdm.be[i]) mem[idx][8*i +: 8] <= tcdm.data[8*i +: 8];
    end
  end
  // read response one cycle after handshake; data holds between reads
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_valid <= rd_hs & ~clear_i;
      if (rd_hs) r_data <= mem[idx];
    end
  end
  // saturating transaction counters, zeroed by clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      nb_reads  <= '0;
      nb_writes <= '0;
    end else begin
      nb_reads  <= clear_i ? '0 : nb_reads  + 32'(rd_hs && nb_reads  != '1);
      nb_writes <= clear_i ? '0 : nb_writes + 32'(wr_hs && nb_writes != '1);
    end
  end
  assign tcdm.r_valid = r_valid;
  assign tcdm.r_data  = r_data;
  assign nb_reads_o   = nb_reads;
  assign nb_writes_o  = nb_writes;
endmodule

// File: tb/tb_hwpe_stream_tcdm_responder.sv
// tb_hwpe_stream_tcdm_responder: scoreboard-driven bench for the TCDM responder
module tb_hwpe_stream_tcdm_responder;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b1;
  logic clear_i = 1'b0;
  logic [31:0] nb_reads_o, nb_writes_o;
  hwpe_stream_intf_tcdm tcdm ();
  int tests = 0;
  int fails = 0;
  int nrd = 0;
  int nwr = 0;
  int stall_cycles = 0;
  logic exp_valid = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] model [256];
  hwpe_stream_tcdm_responder #(.STALL_THRESH(128)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (clear_i),
    .tcdm        (tcdm),
    .nb_reads_o  (nb_reads_o),
    .nb_writes_o (nb_writes_o)
  );
  always #5 clk_i = ~clk_i;
  always @(negedge clk_i) begin
    logic [31:0] e;
    if (!rst_ni) begin
      tests++;
      if (tcdm.r_valid !== 1'b0) begin fails++; $display("FAIL rvalid_in_reset got=%b exp=0", tcdm.r_valid); end
      exp_q.delete();
      exp_valid = 1'b0;
    end else begin
      tests++;
      if (tcdm.r_valid !== exp_valid) begin
        fails++; $display("FAIL rvalid_timing t=%0t got=%b exp=%b", $time, tcdm.r_valid, exp_valid);
      end else if (exp_valid) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL scoreboard_empty got=%h exp=<none>", tcdm.r_data);
        end else begin
          e = exp_q.pop_front();
          if (tcdm.r_data !== e) begin fails++; $display("FAIL rdata t=%0t got=%h exp=%h", $time, tcdm.r_data, e); end
        end
      end
      exp_valid = tcdm.req & tcdm.gnt & tcdm.wen & ~clear_i;
    end
  end
  task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
    int n = 0;
    tcdm.req = 1'b1; tcdm.wen = w; tcdm.add = a; tcdm.be = b; tcdm.data = d;
    @(negedge clk_i);
    while (!tcdm.gnt && n < 200) begin stall_cycles++; @(negedge clk_i); n++; end
    if (!tcdm.gnt) begin
      tests++; fails++; $display("FAIL grant_timeout got=0 exp=1 add=%h", a);
    end else begin
      @(posedge clk_i); #1;
      if (w) nrd++; else nwr++;
    end
  endtask
  task automatic idle();
    tcdm.req = 1'b0; tcdm.wen = 1'b0;
    @(posedge clk_i); #1;
  endtask
  task automatic rd(input logic [31:0] a, input logic [31:0] e);
    exp_q.push_back(e);
    issue(1'b1, a, 4'h0, 32'h0);
  endtask
  task automatic chk_counts(input string name);
    tests += 2;
    if (nb_reads_o !== 32'(nrd)) begin fails++; $display("FAIL %s_reads got=%0d exp=%0d", name, nb_reads_o, nrd); end
    if (nb_writes_o !== 32'(nwr)) begin fails++; $display("FAIL %s_writes got=%0d exp=%0d", name, nb_writes_o, nwr); end
  endtask
  task automatic test_reset();
    tcdm.req = 1'b0; tcdm.wen = 1'b0; tcdm.add = '0; tcdm.be = '0; tcdm.data = '0;
    #1 rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    tests += 5;
    if (tcdm.gnt !== 1'b0) begin fails++; $display("FAIL reset_gnt got=%b exp=0", tcdm.gnt); end
    if (tcdm.r_valid !== 1'b0) begin fails++; $display("FAIL reset_rvalid got=%b exp=0", tcdm.r_valid); end
    if (tcdm.r_data !== 32'h0) begin fails++; $display("FAIL reset_rdata got=%h exp=0", tcdm.r_data); end
    if (nb_reads_o !== 32'h0) begin fails++; $display("FAIL reset_nb_reads got=%0d exp=0", nb_reads_o); end
    if (nb_writes_o !== 32'h0) begin fails++; $display("FAIL reset_nb_writes got=%0d exp=0", nb_writes_o); end
    rd(32'h14, 32'h0);
    rd(32'h3FC, 32'h0);
    idle();
    chk_counts("reset");
  endtask
  task automatic test_write_read();
    int r0 = nrd, w0 = nwr;
    issue(1'b0, 32'h10, 4'hF, 32'hDEADBEEF);
    rd(32'h10, 32'hDEADBEEF);
    idle();
    tests += 2;
    if (nb_writes_o !== 32'(w0 + 1)) begin fails++; $display("FAIL wr_rd_writes got=%0d exp=%0d", nb_writes_o, w0 + 1); end
    if (nb_reads_o !== 32'(r0 + 1)) begin fails++; $display("FAIL wr_rd_reads got=%0d exp=%0d", nb_reads_o, r0 + 1); end
  endtask
  task automatic test_byte_enable();
    issue(1'b0, 32'h10, 4'b0101, 32'h11223344);
    rd(32'h10, 32'hDE22BE44);
    issue(1'b0, 32'h12, 4'b0000, 32'hFFFFFFFF);
    rd(32'h11, 32'hDE22BE44);
    idle();
    chk_counts("byte_enable");
  endtask
  task automatic test_wrap();
    issue(1'b0, 32'h400, 4'hF, 32'hCAFEF00D);
    idle();
    rd(32'h0, 32'hCAFEF00D);
    rd(32'hFFFFFC03, 32'hCAFEF00D);
    idle();
    chk_counts("wrap");
  endtask
  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) issue(1'b0, 32'(i * 4), 4'hF, 32'h1000_0000 + 32'(i));
    for (int i = 0; i < 8; i++) rd(32'(i * 4), 32'h1000_0000 + 32'(i));
    idle();
    idle();
    chk_counts("back_to_back");
  endtask
  task automatic test_clear();
    clear_i = 1'b1;
    issue(1'b0, 32'h30, 4'hF, 32'h5A5AA5A5);
    clear_i = 1'b0;
    nrd = 0; nwr = 0;
    chk_counts("clear_write");
    clear_i = 1'b1;
    issue(1'b1, 32'h30, 4'h0, 32'h0);
    clear_i = 1'b0;
    nrd = 0;
    chk_counts("clear_read");
    rd(32'h30, 32'h5A5AA5A5);
    idle();
    chk_counts("after_clear");
  endtask
  task automatic test_reset_mid();
    rd(32'h10, 32'hDE22BE44);
    tcdm.req = 1'b0;
    rst_ni = 1'b0;
    #1;
    tests += 3;
    if (tcdm.r_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_rvalid got=%b exp=0", tcdm.r_valid); end
    if (nb_reads_o !== 32'h0) begin fails++; $display("FAIL rst_mid_reads got=%0d exp=0", nb_reads_o); end
    if (nb_writes_o !== 32'h0) begin fails++; $display("FAIL rst_mid_writes got=%0d exp=0", nb_writes_o); end
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    nrd = 0; nwr = 0;
    rd(32'h10, 32'h0);
    rd(32'h30, 32'h0);
    idle();
    chk_counts("rst_mid");
  endtask
  task automatic test_random_stall();
    for (int i = 0; i < 256; i++) model[i] = '0;
    stall_cycles = 0;
    for (int k = 0; k < 1000; k++) begin
      logic [31:0] a, d;
      logic [3:0] b;
      logic w;
      a = $urandom; d = $urandom; b = 4'($urandom); w = 1'($urandom);
      if (w) rd(a, model[a[9:2]]);
      else begin
        for (int j = 0; j < 4; j++) if (b[j]) model[a[9:2]][8*j +: 8] = d[8*j +: 8];
        issue(1'b0, a, b, d);
      end
      if ($urandom_range(3) == 0) idle();
    end
    idle();
    idle();
    chk_counts("random");
    tests++;
`ifdef HWPE_TCDM_RESPONDER_STALL_EN
    if (stall_cycles == 0) begin fails++; $display("FAIL stall_seen got=%0d exp=>0", stall_cycles); end
`else
    if (stall_cycles != 0) begin fails++; $display("FAIL no_stall got=%0d exp=0", stall_cycles); end
`endif
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size()); end
  endtask
  initial begin
    test_reset();
    test_write_read();
    test_byte_enable();
    test_wrap();
    test_back_to_back();
    test_clear();
    test_reset_mid();
    test_random_stall();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
